// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle from the timing generator to the pixel stage
interface vga_timing_gen_if #(
  parameter int CNT_W = 10
);
  logic             hsync;
  logic             vsync;
  logic             video_on;
  logic [CNT_W-1:0] pixel_x;
  logic [CNT_W-1:0] pixel_y;
  logic             line_start;
  logic             frame_start;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );

  modport slave (
    input hsync, vsync, video_on, pixel_x, pixel_y, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator; optional pixel clock enable under VGA_PIX_CE_EN
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int          CNT_W    = 10
) (
  input  logic             clk,
`ifdef VGA_PIX_CE_EN
  input  logic             pix_ce,
`endif
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC - 1;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

  logic             step;
  logic [CNT_W-1:0] h_q, v_q;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic [31:0]      hx, vx;
  logic             hs_q, vs_q, von_q, ls_q, fs_q;
  logic             hs_nxt, vs_nxt, von_nxt, ls_nxt, fs_nxt;

`ifdef VGA_PIX_CE_EN
  assign step = pix_ce;
`else
  assign step = 1'b1;
`endif

  // ">=" / ">" rather than "==" so a corrupted count recovers within one step
  always_comb begin
    h_nxt = h_q + CNT_W'(1);
    v_nxt = v_q;
    if (h_q >= H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_q >= V_LAST) ? '0 : v_q + CNT_W'(1);
    end
    if (v_q > V_LAST) begin
      v_nxt = '0;
    end
  end

  // Outputs decode the next counts so they line up with pixel_x/pixel_y in the same cycle
  always_comb begin
    hx      = 32'(h_nxt);
    vx      = 32'(v_nxt);
    hs_nxt  = ((hx >= HS_START) && (hx <= HS_END)) ? H_POL : ~H_POL;
    vs_nxt  = ((vx >= VS_START) && (vx <= VS_END)) ? V_POL : ~V_POL;
    von_nxt = (hx < H_ACTIVE) && (vx < V_ACTIVE);
    ls_nxt  = (h_nxt == '0);
    fs_nxt  = (h_nxt == '0) && (v_nxt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q   <= H_LAST;
      v_q   <= V_LAST;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      von_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else if (step) begin
      h_q   <= h_nxt;
      v_q   <= v_nxt;
      hs_q  <= hs_nxt;
      vs_q  <= vs_nxt;
      von_q <= von_nxt;
      ls_q  <= ls_nxt;
      fs_q  <= fs_nxt;
    end
  end

  assign vga.pixel_x     = h_q;
  assign vga.pixel_y     = v_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.video_on    = von_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized check of two vga_timing_gen configurations against a linear pixel-index model
module tb_vga_timing_gen;

  logic clk;
  logic rst_n;
  logic ce;
  int   total;
  int   bad;

  // config A: small raster with active-high syncs
  localparam int AHA = 8,  AHF = 2, AHS = 2, AHB = 2;
  localparam int AVA = 4,  AVF = 1, AVS = 1, AVB = 1;
  // config B: line total exactly 2**CNT_W, active-low syncs
  localparam int BHA = 20, BHF = 3, BHS = 5, BHB = 4;
  localparam int BVA = 6,  BVF = 2, BVS = 3, BVB = 2;

  localparam int A_FRAME = (AHA + AHF + AHS + AHB) * (AVA + AVF + AVS + AVB);
  localparam int B_FRAME = (BHA + BHF + BHS + BHB) * (BVA + BVF + BVS + BVB);

  vga_timing_gen_if #(.CNT_W(4)) if_a ();
  vga_timing_gen_if #(.CNT_W(5)) if_b ();

  vga_timing_gen #(
    .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
    .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
    .H_POL(1'b1), .V_POL(1'b1), .CNT_W(4)
  ) dut_a (
    .clk    (clk),
`ifdef VGA_PIX_CE_EN
    .pix_ce (ce),
`endif
    .rst_n  (rst_n),
    .vga    (if_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
    .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
    .H_POL(1'b0), .V_POL(1'b0), .CNT_W(5)
  ) dut_b (
    .clk    (clk),
`ifdef VGA_PIX_CE_EN
    .pix_ce (ce),
`endif
    .rst_n  (rst_n),
    .vga    (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // t is the pixel index within the frame; every output is derived from it arithmetically
  task automatic check_dut(input string n, input int t,
                           input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs,
                           input bit hp, input bit vp,
                           input int px, input int py,
                           input bit hsy, input bit vsy, input bit von,
                           input bit ls, input bit fs);
    int ht;
    int h;
    int v;
    ht = ha + hf + hs + hb;
    h  = t % ht;
    v  = t / ht;
    check({n, ".pixel_x"},     px,  h);
    check({n, ".pixel_y"},     py,  v);
    check({n, ".hsync"},       int'(hsy), int'((h >= ha + hf && h < ha + hf + hs) ? hp : !hp));
    check({n, ".vsync"},       int'(vsy), int'((v >= va + vf && v < va + vf + vs) ? vp : !vp));
    check({n, ".video_on"},    int'(von), int'(h < ha && v < va));
    check({n, ".line_start"},  int'(ls),  int'(h == 0));
    check({n, ".frame_start"}, int'(fs),  int'(t == 0));
  endtask

  int t_a;
  int t_b;

  task automatic check_both(input string n);
    check_dut({n, ".a"}, t_a, AHA, AHF, AHS, AHB, AVA, AVF, AVS, 1'b1, 1'b1,
              int'(if_a.pixel_x), int'(if_a.pixel_y), if_a.hsync, if_a.vsync,
              if_a.video_on, if_a.line_start, if_a.frame_start);
    check_dut({n, ".b"}, t_b, BHA, BHF, BHS, BHB, BVA, BVF, BVS, 1'b0, 1'b0,
              int'(if_b.pixel_x), int'(if_b.pixel_y), if_b.hsync, if_b.vsync,
              if_b.video_on, if_b.line_start, if_b.frame_start);
  endtask

  initial begin
    int rst_hold;
    int fs_count_a;
    int active_count_b;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    ce    = 1'b1;
    t_a   = A_FRAME - 1;
    t_b   = B_FRAME - 1;
    rst_hold = 0;
    fs_count_a = 0;
    active_count_b = 0;

    repeat (2) @(negedge clk);
    check_both("reset");
    rst_n = 1'b1;

    // one frame of B with ce always high, counting events as a cross-check
    for (int c = 0; c < B_FRAME; c++) begin
      @(posedge clk);
      t_a = (t_a + 1) % A_FRAME;
      t_b = (t_b + 1) % B_FRAME;
      @(negedge clk);
      if (c == 0) begin
        check("first.a.video_on", int'(if_a.video_on), 1);
        check("first.a.frame_start", int'(if_a.frame_start), 1);
        check("first.b.line_start", int'(if_b.line_start), 1);
      end
      if (c == 1) begin
        check("second.a.frame_start", int'(if_a.frame_start), 0);
        check("second.b.line_start", int'(if_b.line_start), 0);
      end
      check_both("run");
      if (if_a.frame_start) fs_count_a++;
      if (if_b.video_on) active_count_b++;
    end
    check("count.a.frames", fs_count_a, (B_FRAME + A_FRAME - 1) / A_FRAME);
    check("count.b.active", active_count_b, BHA * BVA);

    for (int c = 0; c < 4000; c++) begin
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if (c > 20 && $urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        t_a = A_FRAME - 1;
        t_b = B_FRAME - 1;
        check_both("arst");
        rst_hold = $urandom_range(1, 3);
      end
`ifdef VGA_PIX_CE_EN
      ce = ($urandom_range(0, 3) != 0);
`else
      ce = 1'b1;
`endif
      @(posedge clk);
      if (rst_n && ce) begin
        t_a = (t_a + 1) % A_FRAME;
        t_b = (t_b + 1) % B_FRAME;
      end
      @(negedge clk);
      check_both("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
